// File: rtl/hps_pkg.sv
// Shared definitions for the harmonic product spectrum block: state
// encoding, harmonic count and the fixed write-to-output latency.
package hps_pkg;

  typedef enum logic [1:0] {
    ST_FILL    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_FLUSH   = 2'd2
  } hps_state_e;

  localparam int HARMONICS    = 3;
  localparam int PIPE_LATENCY = 6;

endpackage

// File: rtl/spectrum_ram.sv
// Single-write, single-read spectrum buffer with a registered read port.
// Contents are never cleared so a frame may reuse bins from the previous one.
module spectrum_ram
  import hps_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 11
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem_q [2**ADDR_W];
  logic [DATA_W-1:0] rdata_q;

  // Storage write and one-cycle registered read.
  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[waddr] <= wdata;
    end
    if (re) begin
      rdata_q <= mem_q[raddr];
    end
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/harmonic_product.sv
// Harmonic product spectrum: for each bin k outputs bin[k]*bin[2k]*bin[3k].
// Optional feature macro HPS_DC_REJECT_EN forces the k=0 product to zero.
module harmonic_product
  import hps_pkg::*;
#(
  parameter int IN_WIDTH = 32,
  parameter int K_WIDTH  = 11
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  data_valid,
  input  logic [IN_WIDTH-1:0]   data_in,
  input  logic [K_WIDTH-1:0]    k_in,
  output logic                  in_ready,
  output logic                  frame_start,
  output logic                  out_valid,
  output logic [3*IN_WIDTH-1:0] product_out,
  output logic [K_WIDTH-1:0]    k_out,
  output logic                  overrun
);

  localparam int PROD_W = 3 * IN_WIDTH;
  localparam int KX_W   = K_WIDTH + 2;
  localparam logic [K_WIDTH-1:0] MAX_K    = {K_WIDTH{1'b1}};
  localparam logic [KX_W-1:0]    MAX_K_X  = {2'b00, MAX_K};
  localparam logic [K_WIDTH-1:0] K_ONE    = {{(K_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [1:0]         LAST_PH  = 2'(HARMONICS - 1);

  hps_state_e state_q, state_d;
  logic [K_WIDTH-1:0]    k_q, k_d;
  logic [1:0]            phase_q, phase_d;
  logic                  in_ready_q, in_ready_d;
  logic                  frame_start_q, frame_start_d;
  logic                  overrun_q, overrun_d;
  logic                  rd_act_q, rd_act_d;
  logic [1:0]            rd_ph_q, rd_ph_d;
  logic [K_WIDTH-1:0]    rd_k_q, rd_k_d;
  logic                  rd_zero_q, rd_zero_d;
  logic [IN_WIDTH-1:0]   a_q, a_d;
  logic [2*IN_WIDTH-1:0] ab_q, ab_d;
  logic [PROD_W-1:0]     prod_q, prod_d;
  logic                  prod_valid_q, prod_valid_d;
  logic [K_WIDTH-1:0]    prod_k_q, prod_k_d;
  logic                  out_valid_q, out_valid_d;
  logic [PROD_W-1:0]     product_out_q, product_out_d;
  logic [K_WIDTH-1:0]    k_out_q, k_out_d;

  logic [KX_W-1:0]     k_x2_s, k_x3_s;
  logic                k_zero_s;
  logic                ram_we_s, ram_re_s;
  logic [K_WIDTH-1:0]  ram_raddr_s;
  logic [IN_WIDTH-1:0] ram_rdata_s;
  logic                dc_kill_s;

  spectrum_ram #(
    .DATA_W (IN_WIDTH),
    .ADDR_W (K_WIDTH)
  ) u_spectrum_ram (
    .clock (clock),
    .we    (ram_we_s),
    .waddr (k_in),
    .wdata (data_in),
    .re    (ram_re_s),
    .raddr (ram_raddr_s),
    .rdata (ram_rdata_s)
  );

  // Harmonic addresses; a bin whose 3k lies past the frame yields zero and is never read.
  always_comb begin
    k_x2_s   = {1'b0, k_q, 1'b0};
    k_x3_s   = k_x2_s + {2'b00, k_q};
    k_zero_s = (k_x3_s > MAX_K_X);
  end

  // Frame sequencing: fill, read issue (k, 2k, 3k per bin), then drain.
  always_comb begin
    state_d       = state_q;
    k_d           = k_q;
    phase_d       = phase_q;
    frame_start_d = 1'b0;
    overrun_d     = overrun_q;
    rd_act_d      = 1'b0;
    rd_ph_d       = phase_q;
    rd_k_d        = k_q;
    rd_zero_d     = k_zero_s;
    ram_we_s      = 1'b0;
    ram_re_s      = 1'b0;
    ram_raddr_s   = k_q;
    case (state_q)
      ST_FILL: begin
        if (data_valid) begin
          ram_we_s = ~reset;
          if (k_in == MAX_K) begin
            state_d       = ST_COMPUTE;
            k_d           = {K_WIDTH{1'b0}};
            phase_d       = 2'd0;
            frame_start_d = 1'b1;
          end else begin
            state_d = ST_FILL;
          end
        end else begin
          state_d = ST_FILL;
        end
      end
      ST_COMPUTE: begin
        if (data_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        rd_act_d = 1'b1;
        ram_re_s = ~k_zero_s;
        case (phase_q)
          2'd0:    ram_raddr_s = k_q;
          2'd1:    ram_raddr_s = k_x2_s[K_WIDTH-1:0];
          default: ram_raddr_s = k_x3_s[K_WIDTH-1:0];
        endcase
        if (phase_q == LAST_PH) begin
          phase_d = 2'd0;
          k_d     = k_q + K_ONE;
          if (k_q == MAX_K) begin
            state_d = ST_FLUSH;
          end else begin
            state_d = ST_COMPUTE;
          end
        end else begin
          phase_d = phase_q + 2'd1;
        end
      end
      ST_FLUSH: begin
        if (data_valid) begin
          overrun_d = 1'b1;
        end else begin
          overrun_d = overrun_q;
        end
        if (out_valid_q && (k_out_q == MAX_K)) begin
          state_d = ST_FILL;
        end else begin
          state_d = ST_FLUSH;
        end
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
    in_ready_d = (state_d == ST_FILL);
  end

  // Optional suppression of the DC bin result.
  always_comb begin
`ifdef HPS_DC_REJECT_EN
    dc_kill_s = (rd_k_q == {K_WIDTH{1'b0}});
`else
    dc_kill_s = 1'b0;
`endif
  end

  // Multiply pipeline: accumulate the three harmonic words as they return from the buffer.
  always_comb begin
    a_d          = a_q;
    ab_d         = ab_q;
    prod_d       = prod_q;
    prod_valid_d = 1'b0;
    prod_k_d     = prod_k_q;
    if (rd_act_q) begin
      case (rd_ph_q)
        2'd0: begin
          a_d = rd_zero_q ? {IN_WIDTH{1'b0}} : ram_rdata_s;
        end
        2'd1: begin
          ab_d = rd_zero_q ? {(2*IN_WIDTH){1'b0}}
                           : ({{IN_WIDTH{1'b0}}, a_q} * {{IN_WIDTH{1'b0}}, ram_rdata_s});
        end
        default: begin
          prod_valid_d = 1'b1;
          prod_k_d     = rd_k_q;
          prod_d       = (rd_zero_q || dc_kill_s) ? {PROD_W{1'b0}}
                         : ({{IN_WIDTH{1'b0}}, ab_q} * {{(2*IN_WIDTH){1'b0}}, ram_rdata_s});
        end
      endcase
    end else begin
      prod_valid_d = 1'b0;
    end
    out_valid_d = prod_valid_q;
    if (prod_valid_q) begin
      product_out_d = prod_q;
      k_out_d       = prod_k_q;
    end else begin
      product_out_d = product_out_q;
      k_out_d       = k_out_q;
    end
  end

  // State and pipeline registers; reset abandons any frame but leaves the buffer intact.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= ST_FILL;
      k_q           <= {K_WIDTH{1'b0}};
      phase_q       <= 2'd0;
      in_ready_q    <= 1'b1;
      frame_start_q <= 1'b0;
      overrun_q     <= 1'b0;
      rd_act_q      <= 1'b0;
      rd_ph_q       <= 2'd0;
      rd_k_q        <= {K_WIDTH{1'b0}};
      rd_zero_q     <= 1'b0;
      a_q           <= {IN_WIDTH{1'b0}};
      ab_q          <= {(2*IN_WIDTH){1'b0}};
      prod_q        <= {PROD_W{1'b0}};
      prod_valid_q  <= 1'b0;
      prod_k_q      <= {K_WIDTH{1'b0}};
      out_valid_q   <= 1'b0;
      product_out_q <= {PROD_W{1'b0}};
      k_out_q       <= {K_WIDTH{1'b0}};
    end else begin
      state_q       <= state_d;
      k_q           <= k_d;
      phase_q       <= phase_d;
      in_ready_q    <= in_ready_d;
      frame_start_q <= frame_start_d;
      overrun_q     <= overrun_d;
      rd_act_q      <= rd_act_d;
      rd_ph_q       <= rd_ph_d;
      rd_k_q        <= rd_k_d;
      rd_zero_q     <= rd_zero_d;
      a_q           <= a_d;
      ab_q          <= ab_d;
      prod_q        <= prod_d;
      prod_valid_q  <= prod_valid_d;
      prod_k_q      <= prod_k_d;
      out_valid_q   <= out_valid_d;
      product_out_q <= product_out_d;
      k_out_q       <= k_out_d;
    end
  end

  assign in_ready    = in_ready_q;
  assign frame_start = frame_start_q;
  assign overrun     = overrun_q;
  assign out_valid   = out_valid_q;
  assign product_out = product_out_q;
  assign k_out       = k_out_q;

endmodule

// File: doc/harmonic_product.md
HARMONIC_PRODUCT -- requirements
Module: harmonic_product

Interface
REQ-001 SHALL have parameter IN_WIDTH, default 32: width of one unsigned FFT-bin magnitude-squared word.
REQ-002 SHALL have parameter K_WIDTH, default 11: bin index width; frame length N = 2^K_WIDTH, MAX_K = N-1.
REQ-003 SHALL have port clock, input, 1: sole clock; all logic on its rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port data_valid, input, 1: qualifies data_in/k_in.
REQ-006 SHALL have port data_in, input, IN_WIDTH: bin magnitude, unsigned.
REQ-007 SHALL have port k_in, input, K_WIDTH: bin index of data_in.
REQ-008 SHALL have port in_ready, output, 1: high while input is accepted (FILL state).
REQ-009 SHALL have port frame_start, output, 1: one-cycle pulse marking start of a new output frame; drives the downstream maximum tracker's reset.
REQ-010 SHALL have port out_valid, output, 1: qualifies product_out/k_out.
REQ-011 SHALL have port product_out, output, 3*IN_WIDTH: harmonic product, unsigned.
REQ-012 SHALL have port k_out, output, K_WIDTH: bin index of product_out, strictly increasing within a frame.
REQ-013 SHALL have port overrun, output, 1: sticky flag, input dropped while busy.

Function
REQ-014 SHALL implement states FILL, COMPUTE, FLUSH.
REQ-015 FILL: each data_valid cycle SHALL write data_in to spectrum buffer address k_in; any order accepted; unwritten bins keep prior-frame contents.
REQ-016 A FILL write with k_in == MAX_K SHALL move to COMPUTE next cycle; frame_start SHALL pulse in that first COMPUTE cycle.
REQ-017 COMPUTE SHALL, for k = 0..MAX_K ascending, issue reads at addresses k, 2k, 3k on three consecutive cycles (one result per 3 cycles).
REQ-018 product_out SHALL equal bin[k]*bin[2k]*bin[3k], full 3*IN_WIDTH precision, no truncation or saturation.
REQ-019 When 3k > MAX_K, product_out SHALL be 0 and no out-of-range read SHALL be issued; k_out still emitted so the frame always ends at k_out == MAX_K.
REQ-020 Taking the MAX_K write cycle as cycle 0, out_valid for k SHALL assert in cycle 6+3k, for exactly one cycle.
REQ-021 After the last read is issued, state SHALL be FLUSH until the k = MAX_K result is output, then FILL the following cycle.
REQ-022 in_ready SHALL be high only in FILL.
REQ-023 data_valid with in_ready low SHALL be ignored (no buffer write) and SHALL set overrun, which holds until reset.
REQ-024 out_valid SHALL be low outside COMPUTE/FLUSH.

Reset
REQ-025 Reset SHALL force FILL; in_ready=1, out_valid=0, frame_start=0, overrun=0, product_out=0, k_out=0, pipeline valids cleared, from the cycle after reset is sampled.
REQ-026 Reset mid-COMPUTE/FLUSH SHALL abandon the frame with no further out_valid; buffer contents SHALL NOT be cleared.
REQ-027 Reset SHALL take priority over a simultaneous data_valid.

Configuration
REQ-028 Macro HPS_DC_REJECT_EN defined: the k=0 result SHALL be forced to 0, timing unchanged.
REQ-029 Macro HPS_DC_REJECT_EN undefined: the k=0 result SHALL be bin[0]^3 per REQ-018.

Structure
REQ-030 Package hps_pkg SHALL hold the state encoding, HARMONICS = 3 and the fixed pipeline latency constant (6).
REQ-031 Spectrum storage SHALL be sub-module spectrum_ram: N x IN_WIDTH, one write port, one read port, 1-cycle registered read.

Verification (bench uses K_WIDTH=4, IN_WIDTH=32)
REQ-032 All 16 bins = 2 -> k_out 0..5 product 8, k_out 6..15 product 0; first out_valid cycle 6, last cycle 51.
REQ-033 bin[k] = k+1 -> k_out=2 product 105 (3*5*7), k_out=5 product 6*11*16 = 1056.
REQ-034 bins 1,2,3 = 0xFFFFFFFF -> k_out=1 product = (2^32-1)^3, exact 96 bits.
REQ-035 data_valid pulses during COMPUTE -> overrun=1, no buffer write, results identical to an undisturbed run.
REQ-036 reset asserted at cycle 20 of COMPUTE -> next cycle out_valid=0, in_ready=1; next frame correct with prior buffer data.
REQ-037 HPS_DC_REJECT_EN defined, bin[0]=5 -> k_out=0 product 0; undefined -> 125.
